l1_load_miss_queue: RTL and testbench
=====================================

# l1_load_miss_queue

Tracks outstanding L1 data-cache line misses between the tag stage and the L2 interface. Each miss detected after tag lookup allocates an entry, or merges into an existing one for the same line. Entries issue L2 fill requests over a valid/ready handshake. When L2 responds, the block drives the tag-memory update port and wakes every strand waiting on that line.

## Interface
Parameters:
- NUM_ENTRIES, 4: outstanding-miss entries; power of two, 2..16.
- NUM_STRANDS, 4: strands that can wait on a line.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- request_i  in  1  miss from tag stage (access latched && !cache_hit)
- request_addr  in  26  line address, {tag, set}
- request_way  in  2  victim way chosen for fill
- request_strand  in  $clog2(NUM_STRANDS)  requesting strand
- full_o  out  1  no IDLE entry free
- l2_req_valid  out  1  fill request valid
- l2_req_ready  in  1  L2 accepts request
- l2_req_addr  out  26  line address of request
- l2_req_id  out  $clog2(NUM_ENTRIES)  entry index
- l2_rsp_valid  in  1  fill complete
- l2_rsp_id  in  $clog2(NUM_ENTRIES)  entry being completed
- update_o  out  1  to tag update_i
- update_way_o  out  2  to tag update_way_i
- update_tag_o  out  L1_TAG_WIDTH  to tag update_tag_i
- update_set_o  out  L1_SET_INDEX_WIDTH  to tag update_set_i
- wake_bitmap_o  out  NUM_STRANDS  strands to restart, one-cycle pulse

## Operation
- Entry fields: state, addr[25:0], way[1:0], waiting bitmap[NUM_STRANDS].
- Entry states: IDLE, PENDING, ISSUED.
- Allocation (request_i=1): compare request_addr against every non-IDLE entry.
  - Match: OR the strand bit into that entry's bitmap. No allocation; allowed even when full_o=1.
  - No match: the lowest-index IDLE entry goes to PENDING with addr, way and the single strand bit.
- request_i=1 with no match while full_o=1 is illegal (simulation assertion). The tag stage stalls on full_o.
- At most one non-IDLE entry per line address at any time. This guarantees the tag stage never sees two ways hit.
- Issue: the arbiter selects one PENDING entry and drives l2_req_valid/addr/id.
  - Selection changes only after the handshake completes; fields hold stable while valid && !ready.
  - valid && ready: the entry goes PENDING->ISSUED at that edge.
- Response: l2_rsp_valid with an ISSUED id sends that entry to IDLE at that edge. The next cycle carries update_o=1, the entry's way/tag/set, and wake_bitmap_o = its bitmap.
- l2_rsp_valid for a non-ISSUED id is ignored (simulation assertion).

## Timing
- Reset: all entries IDLE; full_o, l2_req_valid, update_o = 0; wake_bitmap_o = 0; arbiter pointer = 0.
- full_o and l2_req_* are combinational from entry state; the allocation compare is combinational on request_*.
- Miss to earliest l2_req_valid: 1 cycle, since the entry is PENDING after the allocating edge.
- Response to update_o/wake_bitmap_o: 1 cycle, registered.
- A freed entry is allocatable in the cycle after the response edge. full_o deasserts in that cycle.
- Simultaneous request merge and response for the same entry:
  - The new strand bit is included in that response's wake_bitmap_o.
  - No new entry is allocated.
- Simultaneous allocation and issue handshake on different entries: both take effect.
- Same-cycle issue and response for the same id is impossible (PENDING is not ISSUED) and is asserted against.
- Reset mid-operation drops all entries. L2 responses arriving after reset fall under the ignored/asserted rule.

## Configuration
- L1_MISS_QUEUE_RR_EN defined: round-robin issue.
  - The pointer advances to the granted index +1 on each handshake.
  - Search starts at the pointer, with wrap-around.
- Undefined: fixed priority, lowest-index PENDING entry first; the pointer logic is removed.
- Allocation policy is identical in both builds.

## Structure
- Shared package (defines.v): L1_TAG_WIDTH, L1_SET_INDEX_WIDTH, L1_NUM_WAYS, and the entry-state enum typedef miss_state_t.
- Sub-module l1_miss_issue_arbiter: request vector in; grant one-hot, grant index and valid out.
  - Round-robin/fixed selection lives here, under the macro.

## Test plan
- Single miss: addr 0x12345, way 2, strand 1 -> l2_req_valid next cycle with id 0. Respond id 0 -> one cycle later update_o=1, way 2, tag/set split of 0x12345, wake 4'b0010.
- Merge: strands 0, 2, 3 miss on 0x00abc on consecutive cycles -> a single entry and a single L2 request; response -> wake 4'b1101.
- Fill queue: 4 distinct misses -> full_o=1. A 5th distinct miss must not be issued, while a 5th miss matching entry 1 merges. Respond id 1 -> full_o=0 the next cycle.
- Backpressure: hold l2_req_ready=0 for 5 cycles -> l2_req_addr/id stable. Ready=1 -> entry ISSUED and the next PENDING entry presented.
- Round-robin (macro on): entries 0–3 PENDING, ready always 1 -> grants 0,1,2,3. After entry 0 is re-armed, its next grant follows 3. Macro off -> lowest index always first.
- Reset with 3 entries ISSUED -> all outputs 0. A later response id 2 produces no update_o.

Source files
------------

// File: rtl/l1_load_miss_queue_pkg.sv
// Shared L1 miss-queue definitions: cache geometry and the miss-entry state encoding.
package l1_load_miss_queue_pkg;

  localparam int unsigned L1_NUM_WAYS        = 4;
  localparam int unsigned L1_WAY_WIDTH       = $clog2(L1_NUM_WAYS);
  localparam int unsigned L1_SET_INDEX_WIDTH = 6;
  localparam int unsigned L1_TAG_WIDTH       = 20;
  localparam int unsigned L1_LINE_ADDR_WIDTH = L1_TAG_WIDTH + L1_SET_INDEX_WIDTH;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StIssued  = 2'd2
  } miss_state_t;

endpackage

// File: rtl/l1_miss_issue_arbiter.sv
// Picks one PENDING miss entry for L2 issue and holds it until the handshake completes.
// L1_MISS_QUEUE_RR_EN selects round-robin order; otherwise the lowest index wins.
module l1_miss_issue_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumReq-1:0]         req_i,
  input  logic                      ready_i,
  output logic [NumReq-1:0]         grant_o,
  output logic [$clog2(NumReq)-1:0] grant_idx_o,
  output logic                      grant_valid_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] sel_idx;
  logic            sel_valid;

`ifdef L1_MISS_QUEUE_RR_EN
  logic [IdxW-1:0] ptr_q;

  // Scan downward so the smallest offset from the pointer is the last (winning) assignment.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      if (req_i[ptr_q + IdxW'(k)]) begin
        sel_valid = 1'b1;
        sel_idx   = ptr_q + IdxW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant_valid_o && ready_i) begin
      ptr_q <= grant_idx_o + IdxW'(1);
    end
  end
`else
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(k);
      end
    end
  end
`endif

  // A request presented without ready stays selected so L2 sees stable addr/id.
  always_comb begin
    grant_valid_o = sel_valid;
    grant_idx_o   = sel_idx;
    if (lock_q && req_i[lock_idx_q]) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = lock_idx_q;
    end
    grant_o = '0;
    if (grant_valid_o) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= grant_valid_o && !ready_i;
      lock_idx_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/l1_load_miss_queue.sv
// Outstanding L1 load-miss tracker: allocates or merges misses, issues L2 fills, then drives the
// tag update and strand wake-up. Define L1_MISS_QUEUE_RR_EN for round-robin issue order.
module l1_load_miss_queue
  import l1_load_miss_queue_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned NUM_STRANDS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           request_i,
  input  logic [L1_LINE_ADDR_WIDTH-1:0]  request_addr,
  input  logic [L1_WAY_WIDTH-1:0]        request_way,
  input  logic [$clog2(NUM_STRANDS)-1:0] request_strand,
  output logic                           full_o,
  output logic                           l2_req_valid,
  input  logic                           l2_req_ready,
  output logic [L1_LINE_ADDR_WIDTH-1:0]  l2_req_addr,
  output logic [$clog2(NUM_ENTRIES)-1:0] l2_req_id,
  input  logic                           l2_rsp_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] l2_rsp_id,
  output logic                           update_o,
  output logic [L1_WAY_WIDTH-1:0]        update_way_o,
  output logic [L1_TAG_WIDTH-1:0]        update_tag_o,
  output logic [L1_SET_INDEX_WIDTH-1:0]  update_set_o,
  output logic [NUM_STRANDS-1:0]         wake_bitmap_o
);

  localparam int unsigned IdW = $clog2(NUM_ENTRIES);

  miss_state_t                   state_q  [NUM_ENTRIES];
  miss_state_t                   state_d  [NUM_ENTRIES];
  logic [L1_LINE_ADDR_WIDTH-1:0] addr_q   [NUM_ENTRIES];
  logic [L1_WAY_WIDTH-1:0]       way_q    [NUM_ENTRIES];
  logic [NUM_STRANDS-1:0]        bitmap_q [NUM_ENTRIES];
  logic [NUM_STRANDS-1:0]        bitmap_d [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] match, idle, pending, grant;
  logic [NUM_STRANDS-1:0] strand_bit;
  logic [IdW-1:0]         alloc_idx, grant_idx;
  logic                   hit, alloc, grant_valid, handshake, rsp_hit;

  logic                          update_q;
  logic [L1_WAY_WIDTH-1:0]       upd_way_q;
  logic [L1_LINE_ADDR_WIDTH-1:0] upd_addr_q;
  logic [NUM_STRANDS-1:0]        wake_q;

  always_comb begin
    match      = '0;
    idle       = '0;
    pending    = '0;
    strand_bit = '0;
    strand_bit[request_strand] = 1'b1;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      idle[i]    = (state_q[i] == StIdle);
      pending[i] = (state_q[i] == StPending);
      match[i]   = !idle[i] && (addr_q[i] == request_addr);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (idle[i]) alloc_idx = IdW'(i);
    end
  end

  assign hit       = |match;
  assign full_o    = ~|idle;
  assign alloc     = request_i && !hit && !full_o;
  assign handshake = l2_req_valid && l2_req_ready;
  assign rsp_hit   = l2_rsp_valid && (state_q[l2_rsp_id] == StIssued);

  l1_miss_issue_arbiter #(
    .NumReq (NUM_ENTRIES)
  ) u_arbiter (
    .clk           (clk),
    .reset         (reset),
    .req_i         (pending),
    .ready_i       (l2_req_ready),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign l2_req_valid = grant_valid;
  assign l2_req_id    = grant_idx;
  assign l2_req_addr  = addr_q[grant_idx];

  // A merge landing on the entry being completed still reaches that response's wake bitmap.
  always_comb begin
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      state_d[i]  = state_q[i];
      bitmap_d[i] = bitmap_q[i];
      if (request_i && match[i]) bitmap_d[i] = bitmap_q[i] | strand_bit;
      if (alloc && (alloc_idx == IdW'(i))) begin
        state_d[i]  = StPending;
        bitmap_d[i] = strand_bit;
      end
      if (handshake && grant[i]) state_d[i] = StIssued;
      if (rsp_hit && (l2_rsp_id == IdW'(i))) state_d[i] = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        state_q[i]  <= StIdle;
        addr_q[i]   <= '0;
        way_q[i]    <= '0;
        bitmap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        state_q[i]  <= state_d[i];
        bitmap_q[i] <= bitmap_d[i];
      end
      if (alloc) begin
        addr_q[alloc_idx] <= request_addr;
        way_q[alloc_idx]  <= request_way;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_q   <= 1'b0;
      upd_way_q  <= '0;
      upd_addr_q <= '0;
      wake_q     <= '0;
    end else begin
      update_q   <= rsp_hit;
      upd_way_q  <= way_q[l2_rsp_id];
      upd_addr_q <= addr_q[l2_rsp_id];
      wake_q     <= rsp_hit ? bitmap_d[l2_rsp_id] : '0;
    end
  end

  assign update_o      = update_q;
  assign update_way_o  = upd_way_q;
  assign update_tag_o  = upd_addr_q[L1_LINE_ADDR_WIDTH-1:L1_SET_INDEX_WIDTH];
  assign update_set_o  = upd_addr_q[L1_SET_INDEX_WIDTH-1:0];
  assign wake_bitmap_o = wake_q;

  // The tag stage stalls on full_o, so only merges may arrive while full.
  assert property (@(posedge clk) disable iff (reset) !(request_i && !hit && full_o))
    else $error("miss queue: allocation attempted while full");

  assert property (@(posedge clk) disable iff (reset) $onehot0(match))
    else $error("miss queue: line tracked by more than one entry");

  assert property (@(posedge clk) disable iff (reset) !(l2_rsp_valid && !rsp_hit))
    else $warning("miss queue: response for entry %0d not ISSUED, ignored", l2_rsp_id);

endmodule

// File: tb/tb_l1_load_miss_queue.sv
// Self-checking bench for l1_load_miss_queue: vector table plus hand-written arbitration/reset
// sequences, with a scoreboard of expected tag updates.
module tb_l1_load_miss_queue;

`ifdef L1_MISS_QUEUE_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        request_i;
  logic [25:0] request_addr;
  logic [1:0]  request_way;
  logic [1:0]  request_strand;
  logic        full_o;
  logic        l2_req_valid;
  logic        l2_req_ready;
  logic [25:0] l2_req_addr;
  logic [1:0]  l2_req_id;
  logic        l2_rsp_valid;
  logic [1:0]  l2_rsp_id;
  logic        update_o;
  logic [1:0]  update_way_o;
  logic [19:0] update_tag_o;
  logic [5:0]  update_set_o;
  logic [3:0]  wake_bitmap_o;

  always #5 clk = ~clk;

  l1_load_miss_queue dut (
    .clk            (clk),
    .reset          (reset),
    .request_i      (request_i),
    .request_addr   (request_addr),
    .request_way    (request_way),
    .request_strand (request_strand),
    .full_o         (full_o),
    .l2_req_valid   (l2_req_valid),
    .l2_req_ready   (l2_req_ready),
    .l2_req_addr    (l2_req_addr),
    .l2_req_id      (l2_req_id),
    .l2_rsp_valid   (l2_rsp_valid),
    .l2_rsp_id      (l2_rsp_id),
    .update_o       (update_o),
    .update_way_o   (update_way_o),
    .update_tag_o   (update_tag_o),
    .update_set_o   (update_set_o),
    .wake_bitmap_o  (wake_bitmap_o)
  );

  typedef struct {
    logic        req;
    logic [25:0] addr;
    logic [1:0]  way;
    logic [1:0]  strand;
    logic        rdy;
    logic        rsp;
    logic [1:0]  rsp_id;
    logic        e_full;
    logic        e_vld;
    logic [1:0]  e_id;
    logic [25:0] e_addr;
    logic [1:0]  u_way;
    logic [25:0] u_addr;
    logic [3:0]  u_wake;
  } vec_t;

  typedef struct {
    logic [1:0]  way;
    logic [25:0] addr;
    logic [3:0]  wake;
  } upd_t;

  vec_t vecs[$];
  upd_t sb[$];
  upd_t mon_e;
  upd_t drv_u;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int req, int addr, int way, int strand, int rdy, int rsp,
                              int rsp_id, int e_full, int e_vld, int e_id, int e_addr,
                              int u_way, int u_addr, int u_wake);
    vec_t v;
    v.req = 1'(req);     v.addr = 26'(addr);     v.way = 2'(way);       v.strand = 2'(strand);
    v.rdy = 1'(rdy);     v.rsp = 1'(rsp);        v.rsp_id = 2'(rsp_id);
    v.e_full = 1'(e_full); v.e_vld = 1'(e_vld);  v.e_id = 2'(e_id);     v.e_addr = 26'(e_addr);
    v.u_way = 2'(u_way); v.u_addr = 26'(u_addr); v.u_wake = 4'(u_wake);
    return v;
  endfunction

  task automatic clear_in();
    request_i      = 1'b0;
    request_addr   = '0;
    request_way    = '0;
    request_strand = '0;
    l2_req_ready   = 1'b0;
    l2_rsp_valid   = 1'b0;
    l2_rsp_id      = '0;
  endtask

  task automatic push_upd(input logic [1:0] way, input logic [25:0] addr, input logic [3:0] wake);
    drv_u.way  = way;
    drv_u.addr = addr;
    drv_u.wake = wake;
    sb.push_back(drv_u);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Every update_o pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (update_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got update_o=1 wake=%b, expected no update",
                 wake_bitmap_o);
      end else begin
        mon_e = sb.pop_front();
        check("upd_way", 32'(update_way_o), 32'(mon_e.way));
        check("upd_tag", 32'(update_tag_o), 32'(mon_e.addr[25:6]));
        check("upd_set", 32'(update_set_o), 32'(mon_e.addr[5:0]));
        check("upd_wake", 32'(wake_bitmap_o), 32'(mon_e.wake));
      end
    end
  end

  initial begin
    // req addr way strand | rdy rsp id | full vld id addr | upd way addr wake
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h12345, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 'h12345, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 'h12345, 'b0010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // merge of strands 0, 2, 3 onto one line
    vecs.push_back(mk(1, 'h00abc, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h00abc, 1, 2, 0, 0, 0, 0, 1, 0, 'h00abc, 0, 0, 0));
    vecs.push_back(mk(1, 'h00abc, 1, 3, 1, 0, 0, 0, 1, 0, 'h00abc, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h00abc, 'b1101));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // merge in the same cycle as the response: bit joins wake, nothing allocated
    vecs.push_back(mk(1, 'h3f000, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 'h3f000, 0, 0, 0));
    vecs.push_back(mk(1, 'h3f000, 3, 2, 0, 1, 0, 0, 0, 0, 0, 3, 'h3f000, 'b0101));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fill the queue, merge while full, drain
    vecs.push_back(mk(1, 'h01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h02000, 1, 1, 0, 0, 0, 0, 1, 0, 'h01000, 0, 0, 0));
    vecs.push_back(mk(1, 'h03000, 2, 2, 0, 0, 0, 0, 1, 0, 'h01000, 0, 0, 0));
    vecs.push_back(mk(1, 'h04000, 3, 3, 0, 0, 0, 0, 1, 0, 'h01000, 0, 0, 0));
    vecs.push_back(mk(1, 'h02000, 1, 3, 0, 0, 0, 1, 1, 0, 'h01000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 'h01000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 'h02000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 'h03000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 3, 'h04000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 'h02000, 'b1010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'h01000, 'b0001));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 2, 'h03000, 'b0100));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 3, 'h04000, 'b1000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // backpressure: presented request stays put, even when a lower index turns PENDING
    vecs.push_back(mk(1, 'h2aaaa, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h15555, 1, 1, 0, 0, 0, 0, 1, 0, 'h2aaaa, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h2aaaa, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 'h2aaaa, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h15555, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 'h15555, 0, 'h2aaaa, 'b0001));
    vecs.push_back(mk(1, 'h00777, 2, 2, 0, 0, 0, 0, 1, 1, 'h15555, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h15555, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 'h15555, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 'h00777, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 'h15555, 'b0010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 'h00777, 'b0100));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    reset = 1'b1;
    clear_in();
    next_cycle();
    @(negedge clk);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_req_valid", 32'(l2_req_valid), 32'd0);
    check("rst_update", 32'(update_o), 32'd0);
    check("rst_wake", 32'(wake_bitmap_o), 32'd0);
    next_cycle();
    reset = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      request_i      = vecs[n].req;
      request_addr   = vecs[n].addr;
      request_way    = vecs[n].way;
      request_strand = vecs[n].strand;
      l2_req_ready   = vecs[n].rdy;
      l2_rsp_valid   = vecs[n].rsp;
      l2_rsp_id      = vecs[n].rsp_id;
      if (vecs[n].rsp) push_upd(vecs[n].u_way, vecs[n].u_addr, vecs[n].u_wake);
      @(negedge clk);
      check($sformatf("v%0d_full", n), 32'(full_o), 32'(vecs[n].e_full));
      check($sformatf("v%0d_req_valid", n), 32'(l2_req_valid), 32'(vecs[n].e_vld));
      if (vecs[n].e_vld) begin
        check($sformatf("v%0d_req_id", n), 32'(l2_req_id), 32'(vecs[n].e_id));
        check($sformatf("v%0d_req_addr", n), 32'(l2_req_addr), 32'(vecs[n].e_addr));
      end
      next_cycle();
    end

    // Arbitration order: 0, 1, 2, then entry 0 re-armed alongside 3.
    clear_in();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      request_i      = 1'b1;
      request_addr   = 26'h20000 | 26'(i);
      request_way    = 2'(i);
      request_strand = 2'(i);
      next_cycle();
    end
    clear_in();
    l2_req_ready = 1'b1;
    @(negedge clk);
    check("arb_g0_valid", 32'(l2_req_valid), 32'd1);
    check("arb_g0", 32'(l2_req_id), 32'd0);
    next_cycle();
    @(negedge clk);
    check("arb_g1", 32'(l2_req_id), 32'd1);
    next_cycle();
    l2_req_ready = 1'b0;
    @(negedge clk);
    check("arb_g2_hold", 32'(l2_req_id), 32'd2);
    next_cycle();
    l2_rsp_valid = 1'b1;
    l2_rsp_id    = 2'd0;
    push_upd(2'd0, 26'h20000, 4'b0001);
    @(negedge clk);
    check("arb_g2_hold_rsp", 32'(l2_req_id), 32'd2);
    next_cycle();
    // allocation of entry 0 and handshake of entry 2 in the same cycle
    l2_rsp_valid   = 1'b0;
    request_i      = 1'b1;
    request_addr   = 26'h3abcd;
    request_way    = 2'd1;
    request_strand = 2'd3;
    l2_req_ready   = 1'b1;
    @(negedge clk);
    check("arb_g2_valid", 32'(l2_req_valid), 32'd1);
    check("arb_g2", 32'(l2_req_id), 32'd2);
    next_cycle();
    clear_in();
    l2_req_ready = 1'b1;
    @(negedge clk);
    check("arb_after_g2", 32'(l2_req_id), RrEn ? 32'd3 : 32'd0);
    check("arb_after_g2_addr", 32'(l2_req_addr), RrEn ? 32'h20003 : 32'h3abcd);
    next_cycle();
    @(negedge clk);
    check("arb_last", 32'(l2_req_id), RrEn ? 32'd0 : 32'd3);
    next_cycle();
    l2_req_ready = 1'b0;
    @(negedge clk);
    check("arb_drained", 32'(l2_req_valid), 32'd0);
    l2_rsp_valid = 1'b1;
    l2_rsp_id    = 2'd1;
    push_upd(2'd1, 26'h20001, 4'b0010);
    next_cycle();
    clear_in();
    next_cycle();

    // Reset with entries 0, 2, 3 ISSUED; a stale response must not update.
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_full", 32'(full_o), 32'd0);
    check("mid_rst_req_valid", 32'(l2_req_valid), 32'd0);
    check("mid_rst_update", 32'(update_o), 32'd0);
    check("mid_rst_wake", 32'(wake_bitmap_o), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    l2_rsp_valid = 1'b1;
    l2_rsp_id    = 2'd2;
    next_cycle();
    clear_in();
    @(negedge clk);
    check("stale_rsp_update", 32'(update_o), 32'd0);
    check("stale_rsp_wake", 32'(wake_bitmap_o), 32'd0);
    check("stale_rsp_req_valid", 32'(l2_req_valid), 32'd0);
    next_cycle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
